// File: rtl/scan_sched.sv
// Ping-pong sequencer for two capture scanners sharing one transfer channel.
// Latency: every output is registered and changes one clock after the inputs that cause it.
// Backpressure: holds in WAIT until transfer_input grants the channel (or a WAIT flush with SCAN_SCHED_FLUSH_EN).
module scan_sched #(
  parameter int CNT_W      = 8,
  parameter int DEPTH      = 100,
  parameter int HANDOFF    = 80,
  parameter int XFER_TO    = 16,
  parameter int WAIT_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_scan,
  input  logic             stop_scan,
  input  logic             transfer_input,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  output logic [1:0]       scan_en,
  output logic [1:0]       wake,
  output logic [1:0]       xfer_en,
  output logic [1:0]       flush,
  output logic             active,
  output logic             busy,
  output logic             xfer_done,
  output logic [7:0]       xfer_cnt,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, XFER} state_t;

  localparam int TW = $clog2(XFER_TO + 1);

  state_t           state_q, state_d;
  logic             start_q;
  logic             active_q, active_d;
  logic             busy_q;
  logic [1:0]       scan_en_q, scan_en_d;
  logic [1:0]       wake_q, wake_d;
  logic [1:0]       xfer_en_q, xfer_en_d;
  logic             xfer_done_q, xfer_done_d;
  logic [7:0]       xfer_cnt_q, xfer_cnt_d;
  logic             err_q, err_d;
  logic [TW-1:0]    xfer_tmr_q, xfer_tmr_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_a;
  logic             start_edge;

`ifdef SCAN_SCHED_FLUSH_EN
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  logic [1:0]    flush_q, flush_d;
  logic [WW-1:0] wait_tmr_q, wait_tmr_d;
`endif

  function automatic logic [1:0] sel(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  assign cnt_a      = active_q ? cnt1 : cnt0;
  assign start_edge = start_scan && !start_q;

  // Next-state and next-output decode for the scan/wait/transfer sequence.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    scan_en_d   = scan_en_q;
    wake_d      = wake_q;
    xfer_en_d   = xfer_en_q;
    xfer_done_d = 1'b0;
    xfer_cnt_d  = xfer_cnt_q;
    err_d       = err_q;
    xfer_tmr_d  = xfer_tmr_q;
    prev_d      = prev_q;
`ifdef SCAN_SCHED_FLUSH_EN
    flush_d     = 2'b00;
    wait_tmr_d  = wait_tmr_q;
`endif
    case (state_q)
      IDLE: begin
        scan_en_d = 2'b00;
        xfer_en_d = 2'b00;
        wake_d    = 2'b00;
        // A start edge beats a simultaneous stop; stop is looked at again in SCAN.
        if (start_edge) begin
          state_d   = SCAN;
          active_d  = 1'b0;
          scan_en_d = 2'b01;
          err_d     = 1'b0;
        end
      end
      SCAN: begin
        if (cnt_a >= CNT_W'(HANDOFF)) wake_d[~active_q] = 1'b1;
        if (stop_scan && cnt_a == '0) begin
          state_d   = IDLE;
          scan_en_d = 2'b00;
          wake_d    = 2'b00;
        end else if (stop_scan || cnt_a == CNT_W'(DEPTH)) begin
          state_d   = WAIT;
          scan_en_d = 2'b00;
`ifdef SCAN_SCHED_FLUSH_EN
          wait_tmr_d = '0;
`endif
        end
      end
      WAIT: begin
        scan_en_d = 2'b00;
        if (transfer_input) begin
          state_d    = XFER;
          xfer_en_d  = sel(active_q);
          xfer_tmr_d = '0;
          prev_d     = cnt_a;
        end
`ifdef SCAN_SCHED_FLUSH_EN
        // Give up on a full scanner that never gets the channel: discard and swap.
        else begin
          wait_tmr_d = wait_tmr_q + WW'(1);
          if (int'(wait_tmr_q) + 1 >= WAIT_LIMIT) begin
            flush_d            = sel(active_q);
            state_d            = SCAN;
            active_d           = ~active_q;
            scan_en_d          = sel(~active_q);
            wake_d[~active_q]  = 1'b0;
          end
        end
`endif
      end
      XFER: begin
        if (cnt_a == '0) begin
          xfer_done_d = 1'b1;
          xfer_cnt_d  = xfer_cnt_q + 8'd1;
          xfer_en_d   = 2'b00;
          if (stop_scan) begin
            state_d = IDLE;
            wake_d  = 2'b00;
          end else begin
            state_d           = SCAN;
            active_d          = ~active_q;
            scan_en_d         = sel(~active_q);
            wake_d[~active_q] = 1'b0;
          end
        end else begin
          prev_d = cnt_a;
          // Any drop in fill level proves the drain is alive and restarts the timeout.
          if (cnt_a < prev_q) begin
            xfer_tmr_d = '0;
          end else if (int'(xfer_tmr_q) + 1 >= XFER_TO) begin
            err_d     = 1'b1;
            state_d   = IDLE;
            scan_en_d = 2'b00;
            xfer_en_d = 2'b00;
            wake_d    = 2'b00;
          end else begin
            xfer_tmr_d = xfer_tmr_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything including the transfer count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      active_q    <= 1'b0;
      busy_q      <= 1'b0;
      scan_en_q   <= 2'b00;
      wake_q      <= 2'b00;
      xfer_en_q   <= 2'b00;
      xfer_done_q <= 1'b0;
      xfer_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      xfer_tmr_q  <= '0;
      prev_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_scan;
      active_q    <= active_d;
      busy_q      <= (state_d != IDLE);
      scan_en_q   <= scan_en_d;
      wake_q      <= wake_d;
      xfer_en_q   <= xfer_en_d;
      xfer_done_q <= xfer_done_d;
      xfer_cnt_q  <= xfer_cnt_d;
      err_q       <= err_d;
      xfer_tmr_q  <= xfer_tmr_d;
      prev_q      <= prev_d;
    end
  end

`ifdef SCAN_SCHED_FLUSH_EN
  // WAIT starvation timer and the one-cycle flush pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q    <= 2'b00;
      wait_tmr_q <= '0;
    end else begin
      flush_q    <= flush_d;
      wait_tmr_q <= wait_tmr_d;
    end
  end
  assign flush = flush_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^WAIT_LIMIT;
  assign flush      = 2'b00;
`endif

  assign scan_en   = scan_en_q;
  assign wake      = wake_q;
  assign xfer_en   = xfer_en_q;
  assign active    = active_q;
  assign busy      = busy_q;
  assign xfer_done = xfer_done_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_scan_sched.sv
// Scoreboard bench for scan_sched: expected outputs are queued with each stimulus cycle
// and compared against the DUT one clock later, sampled 1 time unit after the rising edge.
module tb_scan_sched;

  typedef struct packed {
    logic [1:0] scan_en;
    logic [1:0] wake;
    logic [1:0] xfer_en;
    logic [1:0] flush;
    logic       active;
    logic       busy;
    logic       xfer_done;
    logic [7:0] xfer_cnt;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_scan, stop_scan, transfer_input;
  logic [7:0] cnt0, cnt1;
  logic [1:0] scan_en, wake, xfer_en, flush;
  logic       active, busy, xfer_done, err;
  logic [7:0] xfer_cnt;

  obs_t  obs;
  obs_t  exp_q[$];
  string tag_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  scan_sched dut (
    .clk(clk), .rst(rst), .start_scan(start_scan), .stop_scan(stop_scan),
    .transfer_input(transfer_input), .cnt0(cnt0), .cnt1(cnt1),
    .scan_en(scan_en), .wake(wake), .xfer_en(xfer_en), .flush(flush),
    .active(active), .busy(busy), .xfer_done(xfer_done), .xfer_cnt(xfer_cnt), .err(err)
  );

  always #5 clk = ~clk;

  assign obs = {scan_en, wake, xfer_en, flush, active, busy, xfer_done, xfer_cnt, err};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (se,wk,xe,fl,act,bsy,done,cnt,err)", tag, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic [1:0] se, input logic [1:0] wk, input logic [1:0] xe,
                              input logic [1:0] fl, input logic ac, input logic bs,
                              input logic dn, input logic [7:0] cn, input logic er);
    return {se, wk, xe, fl, ac, bs, dn, cn, er};
  endfunction

  task automatic pop_cmp();
    obs_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, 32'(obs), 32'(e));
  endtask

  // Drive is already applied; queue the expectation, clock once, compare.
  task automatic tick(input string tag, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic check_now(input string tag, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    pop_cmp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t zero;
    zero = '0;
    rst = 1'b1; start_scan = 0; stop_scan = 0; transfer_input = 0; cnt0 = 0; cnt1 = 0;
    #1;
    check_now("reset", zero);
    #22;
    rst = 1'b0;
    @(posedge clk); #1;

    // Start and stop together: start wins, then stop with empty scanner returns to IDLE.
    start_scan = 1; stop_scan = 1;
    tick("start_wins", mk(2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 0, 8'd0, 0));
    tick("stop_empty", mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'd0, 0));
    stop_scan = 0;
    tick("level_no_edge", zero);
    start_scan = 0;
    tick("idle", zero);
    start_scan = 1;
    tick("start0", mk(2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 0, 8'd0, 0));

    // Fill scanner 0; a start re-edge mid-scan must be ignored.
    for (int v = 1; v <= 100; v++) begin
      cnt0 = 8'(v);
      if (v == 50) start_scan = 0;
      if (v == 51) start_scan = 1;
      if (v == 100)
        tick("fill_wait", mk(2'b00, 2'b10, 2'b00, 2'b00, 0, 1, 0, 8'd0, 0));
      else
        tick("ramp0", mk(2'b01, (v >= 80) ? 2'b10 : 2'b00, 2'b00, 2'b00, 0, 1, 0, 8'd0, 0));
    end
    for (int k = 0; k < 3; k++)
      tick("wait0", mk(2'b00, 2'b10, 2'b00, 2'b00, 0, 1, 0, 8'd0, 0));

    // Transfer scanner 0; dropping transfer_input mid-transfer has no effect.
    transfer_input = 1;
    tick("xfer0", mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 1, 0, 8'd0, 0));
    transfer_input = 0;
    for (int v = 99; v >= 1; v--) begin
      cnt0 = 8'(v);
      tick("drain0", mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 1, 0, 8'd0, 0));
    end
    cnt0 = 0;
    tick("xfer_done0", mk(2'b10, 2'b00, 2'b00, 2'b00, 1, 1, 1, 8'd1, 0));
    tick("scan1", mk(2'b10, 2'b00, 2'b00, 2'b00, 1, 1, 0, 8'd1, 0));

    // Scanner 1 full, then stop requested during its transfer.
    cnt1 = 100;
    tick("fill1", mk(2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 0, 8'd1, 0));
    transfer_input = 1;
    tick("xfer1", mk(2'b00, 2'b01, 2'b10, 2'b00, 1, 1, 0, 8'd1, 0));
    transfer_input = 0; stop_scan = 1; cnt1 = 50;
    tick("xfer1_stop", mk(2'b00, 2'b01, 2'b10, 2'b00, 1, 1, 0, 8'd1, 0));
    cnt1 = 0;
    tick("stop_done", mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 8'd2, 0));
    stop_scan = 0;
    tick("stop_idle", mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 8'd2, 0));

    // Transfer timeout, with one decrease part way restarting the timer.
    start_scan = 0;
    tick("idle2", mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 8'd2, 0));
    start_scan = 1;
    tick("restart", mk(2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 0, 8'd2, 0));
    cnt0 = 100;
    tick("fill_to", mk(2'b00, 2'b10, 2'b00, 2'b00, 0, 1, 0, 8'd2, 0));
    transfer_input = 1;
    tick("xfer_to", mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 1, 0, 8'd2, 0));
    transfer_input = 0;
    for (int k = 1; k <= 27; k++) begin
      cnt0 = (k >= 11) ? 8'd99 : 8'd100;
      if (k < 27)
        tick("xfer_hold", mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 1, 0, 8'd2, 0));
      else
        tick("timeout", mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'd2, 1));
    end
    start_scan = 0;
    tick("err_sticky", mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'd2, 1));
    cnt0 = 0; start_scan = 1;
    tick("err_clear", mk(2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 0, 8'd2, 0));

    // Asynchronous reset mid-SCAN clears everything without a clock edge.
    cnt0 = 50;
    tick("scan50", mk(2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 0, 8'd2, 0));
    #2; rst = 1'b1; start_scan = 0;
    #1;
    check_now("rst_mid", zero);
    #2; rst = 1'b0;
    tick("idle_after_rst", zero);
    start_scan = 1;
    tick("restart2", mk(2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 0, 8'd0, 0));

    // Long WAIT with no transfer permission.
    cnt0 = 100;
    tick("fill_f", mk(2'b00, 2'b10, 2'b00, 2'b00, 0, 1, 0, 8'd0, 0));
`ifdef SCAN_SCHED_FLUSH_EN
    for (int k = 1; k < 64; k++)
      tick("wait_f", mk(2'b00, 2'b10, 2'b00, 2'b00, 0, 1, 0, 8'd0, 0));
    tick("flush", mk(2'b10, 2'b00, 2'b00, 2'b01, 1, 1, 0, 8'd0, 0));
    tick("flush_end", mk(2'b10, 2'b00, 2'b00, 2'b00, 1, 1, 0, 8'd0, 0));
`else
    for (int k = 1; k <= 70; k++)
      tick("no_flush", mk(2'b00, 2'b10, 2'b00, 2'b00, 0, 1, 0, 8'd0, 0));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
